program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter N, 4, data nibble width (matches CPU data width).
REQ-002 SHALL have parameter WORDS, 16, words delivered per load session.
REQ-003 SHALL have parameter DEPTH, 4, input FIFO depth in entries, power of two, minimum 2.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a load session.
REQ-007 in_valid  input  1  source word valid.
REQ-008 in_ready  output  1  loader accepts word this cycle.
REQ-009 in_prog  input  8  instruction byte.
REQ-010 in_data  input  N  data nibble.
REQ-011 clk_load  output  1  load strobe to the CPU program/data store.
REQ-012 myprogram  output  8  instruction byte presented to CPU.
REQ-013 myinput  output  N  data nibble presented to CPU.
REQ-014 word_count  output  5  words strobed this session.
REQ-015 busy  output  1  session in progress.
REQ-016 done  output  1  WORDS words strobed; CPU may run.
REQ-017 exp_sum  input  8  expected checksum.
REQ-018 sum_err  output  1  checksum mismatch, valid while done=1.

Function
REQ-019 States SHALL be IDLE, SETUP, STROBE, GAP, DONE.
REQ-020 Handshake: a word SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; the source holds in_prog/in_data while in_valid=1 and in_ready=0.
REQ-021 in_ready SHALL be 1 iff busy=1, FIFO not full, and words accepted this session < WORDS.
REQ-022 IDLE: start=1 -> SETUP, busy=1; start in any other state except DONE SHALL be ignored.
REQ-023 SETUP: FIFO non-empty -> pop head into myprogram/myinput, go to STROBE; FIFO empty -> stay.
REQ-024 STROBE: clk_load=1 for exactly one cycle, word_count+1 -> GAP.
REQ-025 GAP: clk_load=0; word_count==WORDS -> DONE, else -> SETUP.
REQ-026 myprogram/myinput SHALL be stable from one cycle before clk_load rises until after it falls; minimum 3 cycles per word.
REQ-027 DONE: done=1, busy=0, clk_load=0, outputs held; start -> clear word_count, accepted count, checksum, done -> SETUP.
REQ-028 FIFO push and pop in the same cycle SHALL both occur; a full FIFO SHALL never overwrite; an empty FIFO SHALL never underflow.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH.
REQ-030 Words offered after WORDS accepted SHALL not be accepted (in_ready=0).

Reset
REQ-031 reset=1 SHALL, at the next clk edge, force IDLE, flush FIFO, and set clk_load, myprogram, myinput, word_count, busy, done, sum_err, checksum to 0; priority over all other inputs.
REQ-032 reset mid-session SHALL abort without further strobes; a word held in SETUP/STROBE/GAP SHALL be discarded.

Configuration
REQ-033 Macro LOADER_CHECKSUM_EN defined: running 8-bit XOR of (myprogram ^ zero-extended myinput) SHALL update in STROBE; on entering DONE, sum_err = (checksum != exp_sum).
REQ-034 Macro undefined: no checksum logic; exp_sum ignored; sum_err constant 0; ports unchanged.

Structure
REQ-035 Package loader_pkg SHALL hold the state enum, default N/WORDS/DEPTH constants, and the 5-bit count type.
REQ-036 One sub-module loader_fifo (parameterised width 8+N, DEPTH) SHALL hold the input buffer; FSM and checksum stay in program_loader.

Verification
REQ-037 Reset, start, stream 16 words prog=8'h30+i, data=i with in_valid always 1 -> 16 single-cycle clk_load pulses, each with matching values stable one cycle before rise, done=1, word_count=16.
REQ-038 Source stalls 10 cycles after word 5 -> loader waits in SETUP, clk_load stays 0, session completes with 16 correct words.
REQ-039 in_valid held high with 20 words queued -> exactly 16 accepted, in_ready=0 after 16th acceptance, FIFO never exceeds DEPTH.
REQ-040 reset asserted one cycle after 7th strobe -> next cycle all outputs 0, IDLE; new start loads a fresh 16 with word_count from 0.
REQ-041 LOADER_CHECKSUM_EN: 16 words all prog=8'h5A, data=4'h3 (XOR=8'h00), exp_sum=8'h00 -> sum_err=0; exp_sum=8'h01 -> sum_err=1; macro undefined -> sum_err=0 both cases.
REQ-042 start pulsed mid-session -> ignored, no restart; start in DONE -> new session, done drops next cycle.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: types and default constants shared by the program loader.
//   state_t : loader FSM states (IDLE, SETUP, STROBE, GAP, DONE)
//   count_t : 5-bit word counter type (holds 0..WORDS, WORDS <= 31)
//   N_DEF / WORDS_DEF / DEPTH_DEF : default parameter values
package loader_pkg;

  localparam int N_DEF     = 4;
  localparam int WORDS_DEF = 16;
  localparam int DEPTH_DEF = 4;

  typedef logic [4:0] count_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: small synchronous FIFO buffering {in_prog, in_data} words.
//   clk, reset : clock, synchronous active-high reset (flushes the FIFO)
//   push, din  : write request / data; ignored while full (no overwrite)
//   pop, dout  : read request / head data; ignored while empty (no underflow)
//   full/empty : occupancy flags
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module loader_fifo
  import loader_pkg::*;
#(
  parameter int W     = 8 + N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointer increments wrap modulo DEPTH because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the flushed count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/program_loader.sv
// program_loader: buffers a stream of (instruction byte, data nibble) words
// and presents them to the CPU store one at a time with a clk_load strobe.
//   clk, reset        : clock, synchronous active-high reset
//   start             : one-cycle session request (honoured in IDLE or DONE)
//   in_valid/in_ready : source handshake; a word moves only when both are 1,
//                       the source holds in_prog/in_data while in_ready=0
//   in_prog, in_data  : incoming instruction byte / data nibble
//   clk_load          : one-cycle load strobe to the CPU store
//   myprogram/myinput : word presented to the CPU
//   word_count        : words strobed this session
//   busy / done       : session in progress / WORDS words strobed
//   exp_sum, sum_err  : expected checksum / mismatch flag (valid while done)
// Build option: define LOADER_CHECKSUM_EN to include the XOR checksum;
// otherwise exp_sum is ignored and sum_err is tied to 0.
// The FSM state is held in state_q for observation.
module program_loader
  import loader_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WORDS = WORDS_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_prog,
  input  logic [N-1:0] in_data,
  output logic         clk_load,
  output logic [7:0]   myprogram,
  output logic [N-1:0] myinput,
  output logic [4:0]   word_count,
  output logic         busy,
  output logic         done,
  input  logic [7:0]   exp_sum,
  output logic         sum_err
);

  state_t          state_q;
  state_t          state_d;
  count_t          acc_cnt;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            session_start;
  logic [8+N-1:0]  fifo_dout;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (!fifo_empty) state_d = STROBE;
      STROBE:  state_d = GAP;
      GAP:     state_d = (word_count == count_t'(WORDS)) ? DONE : SETUP;
      DONE:    if (start) state_d = SETUP;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    in_ready      = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    session_start = 1'b0;
    busy          = (state_q == SETUP) || (state_q == STROBE) || (state_q == GAP);
    done          = (state_q == DONE);
    in_ready      = busy && !fifo_full && (acc_cnt < count_t'(WORDS));
    push          = in_valid && in_ready;
    pop           = (state_q == SETUP) && !fifo_empty;
    session_start = start && ((state_q == IDLE) || (state_q == DONE));
  end

  loader_fifo #(
    .W     (8 + N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({in_prog, in_data}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Datapath. The word is latched on leaving SETUP and clk_load is registered
  // from STROBE, so the word sits on the outputs a full cycle before the
  // strobe rises and stays until the next SETUP pop (>= 3 cycles per word).
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_load   <= 1'b0;
      myprogram  <= '0;
      myinput    <= '0;
      word_count <= '0;
      acc_cnt    <= '0;
    end else begin
      clk_load <= (state_q == STROBE);
      if (session_start) begin
        word_count <= '0;
        acc_cnt    <= '0;
      end else begin
        // push only happens while busy, so it never collides with a start
        if (push) acc_cnt <= acc_cnt + 5'd1;
        if (state_q == STROBE) word_count <= word_count + 5'd1;
      end
      if (pop) {myprogram, myinput} <= fifo_dout;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
      sum_err  <= 1'b0;
    end else begin
      if (session_start) begin
        checksum <= '0;
        sum_err  <= 1'b0;
      end else if (state_q == STROBE) begin
        checksum <= checksum ^ myprogram ^ 8'(myinput);
      end
      // Compare once, as the last strobe's contribution is already folded in.
      if ((state_q == GAP) && (state_d == DONE)) sum_err <= (checksum != exp_sum);
    end
  end
`else
  logic unused_exp_sum;
  assign unused_exp_sum = ^exp_sum;
  assign sum_err        = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized self-checking bench for program_loader.
// The reference model is a queue of accepted words: each clk_load rising
// edge must present the oldest accepted word, sessions deliver exactly
// WORDS words, and the checksum expectation is the XOR of delivered words.
// Honours LOADER_CHECKSUM_EN for the sum_err expectation.
module tb_program_loader;

  localparam int N     = 4;
  localparam int WORDS = 16;
  localparam int DEPTH = 4;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_prog;
  logic [N-1:0] in_data;
  logic         clk_load;
  logic [7:0]   myprogram;
  logic [N-1:0] myinput;
  logic [4:0]   word_count;
  logic         busy;
  logic         done;
  logic [7:0]   exp_sum;
  logic         sum_err;

  program_loader #(.N(N), .WORDS(WORDS), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_prog    (in_prog),
    .in_data    (in_data),
    .clk_load   (clk_load),
    .myprogram  (myprogram),
    .myinput    (myinput),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .exp_sum    (exp_sum),
    .sum_err    (sum_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int          n_vec;
  int          n_err;
  logic [11:0] exp_q[$];   // accepted words awaiting their strobe
  logic [11:0] src_q[$];   // words the source still has to offer
  int          phase;      // 0 idle, 1 session active, 2 session done
  int          sess_acc;
  int          sess_strobes;
  logic [7:0]  model_sum;
  logic        prev_clk_load;
  logic [11:0] prev_word;
  int          since_rise;
  bit          accepted_now;
  bit          last_acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Observe one cycle of DUT behaviour against the model.
  task automatic monitor();
    logic [11:0] cur;
    logic [11:0] w;
    cur = {myprogram, myinput};
    if (clk_load) check_eq("pulse_single", prev_clk_load, 1'b0);
    if (clk_load && !prev_clk_load) begin
      check_eq("strobe_has_word", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check_eq("strobe_word", cur, w);
        check_eq("setup_stable", prev_word, w);
        if (sess_strobes > 0) check_eq("strobe_spacing", since_rise >= 3, 1'b1);
        sess_strobes++;
        model_sum = model_sum ^ w[11:4] ^ {4'b0, w[3:0]};
        check_eq("word_count", word_count, sess_strobes);
        check_eq("done_early", done, 1'b0);
      end
      since_rise = 0;
    end
    if (!clk_load && prev_clk_load) check_eq("hold_after_fall", cur, prev_word);
    if (phase == 1 && sess_acc >= WORDS) check_eq("ready_after_limit", in_ready, 1'b0);
    check_eq("fifo_bound", (sess_acc - sess_strobes) <= DEPTH + 1, 1'b1);
    since_rise++;
  endtask

  // One clock: inputs were set by the caller; acceptance is decided from
  // the values that are stable ahead of the rising edge.
  task automatic cycle();
    @(negedge clk);
    accepted_now = in_valid && in_ready && !reset;
    @(posedge clk);
    #1;
    if (reset) begin
      exp_q.delete();
      phase        = 0;
      sess_acc     = 0;
      sess_strobes = 0;
      model_sum    = '0;
    end else begin
      if (start && phase != 1) begin
        phase        = 1;
        sess_acc     = 0;
        sess_strobes = 0;
        model_sum    = '0;
      end
      if (accepted_now) begin
        check_eq("accept_limit", sess_acc < WORDS, 1'b1);
        exp_q.push_back({in_prog, in_data});
        sess_acc++;
      end
      monitor();
    end
    prev_clk_load = clk_load;
    prev_word     = {myprogram, myinput};
    last_acc      = accepted_now;
  endtask

  // Run a load session from src_q. stall_at: accepted count at which the
  // source goes quiet for 10 cycles; mid_start_at: strobe count at which a
  // stray start is pulsed; stop_at: strobe count at which to return early.
  task automatic run_session(input bit rand_valid, input int stall_at,
                             input int mid_start_at, input int stop_at);
    int cyc;
    int stall;
    bit stalled;
    bit mid_done;
    bit stopped;
    start    = 1'b1;
    in_valid = 1'b0;
    cycle();
    start    = 1'b0;
    check_eq("busy_after_start", busy, 1'b1);
    check_eq("done_after_start", done, 1'b0);
    check_eq("count_after_start", word_count, 5'd0);
    cyc = 0; stall = 0; stalled = 0; mid_done = 0; stopped = 0;
    while (!(done && sess_strobes == WORDS) && cyc < 600) begin
      if (stop_at >= 0 && sess_strobes == stop_at) begin
        stopped = 1;
        break;
      end
      if (!(in_valid && !last_acc)) begin
        if (stall_at >= 0 && sess_acc == stall_at && !stalled) begin
          stall   = 10;
          stalled = 1;
        end
        if (stall > 0) begin
          in_valid = 1'b0;
          stall--;
        end else if (src_q.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
          in_valid = 1'b1;
          {in_prog, in_data} = src_q.pop_front();
        end else begin
          in_valid = 1'b0;
        end
      end
      start = 1'b0;
      if (mid_start_at >= 0 && sess_strobes == mid_start_at && !mid_done) begin
        start    = 1'b1;
        mid_done = 1;
      end
      cycle();
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (!stopped) begin
      check_eq("session_done", done, 1'b1);
      check_eq("final_count", word_count, WORDS);
      check_eq("final_strobes", sess_strobes, WORDS);
      check_eq("busy_in_done", busy, 1'b0);
      check_eq("queue_drained", exp_q.size(), 0);
      check_eq("sum_err", sum_err, CK_EN && (model_sum != exp_sum));
      phase = 2;
    end
  endtask

  task automatic fill_random(input int n);
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back(12'($urandom_range(0, 4095)));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_clk_load"}, clk_load, 1'b0);
    check_eq({tag, "_word"}, {myprogram, myinput}, 12'h000);
    check_eq({tag, "_count"}, word_count, 5'd0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_sum_err"}, sum_err, 1'b0);
    check_eq({tag, "_in_ready"}, in_ready, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0; n_err = 0;
    phase = 0; sess_acc = 0; sess_strobes = 0; model_sum = '0;
    prev_clk_load = 1'b0; prev_word = '0; since_rise = 0;
    accepted_now = 0; last_acc = 0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_prog = '0; in_data = '0; exp_sum = '0;

    cycle();
    cycle();
    check_reset_state("reset");
    reset = 1'b0;
    cycle();

    // Sequential pattern, source always valid.
    src_q.delete();
    for (int i = 0; i < WORDS; i++) src_q.push_back({8'(8'h30 + i), 4'(i)});
    exp_sum = 8'h00;
    run_session(1'b0, -1, -1, -1);

    // Source stalls 10 cycles after the fifth word; session started from DONE.
    fill_random(WORDS);
    exp_sum = 8'($urandom_range(0, 255));
    run_session(1'b0, 5, -1, -1);

    // 20 words offered with valid held high, stray start mid-session.
    fill_random(20);
    exp_sum = 8'($urandom_range(0, 255));
    run_session(1'b0, -1, 4, -1);

    // Reset one cycle after the seventh strobe, then a fresh session.
    fill_random(WORDS);
    run_session(1'b1, -1, -1, 7);
    reset    = 1'b1;
    in_valid = 1'b0;
    cycle();
    check_reset_state("abort");
    reset = 1'b0;
    src_q.delete();
    cycle();
    fill_random(WORDS);
    exp_sum = 8'($urandom_range(0, 255));
    run_session(1'b1, -1, -1, -1);

    // Checksum: 16 x {5A,3} XORs to 00.
    for (int k = 0; k < 2; k++) begin
      src_q.delete();
      for (int i = 0; i < WORDS; i++) src_q.push_back({8'h5A, 4'h3});
      exp_sum = (k == 0) ? 8'h00 : 8'h01;
      run_session(1'b0, -1, -1, -1);
    end

    // A few fully random sessions.
    for (int s = 0; s < 3; s++) begin
      fill_random(WORDS + $urandom_range(0, 4));
      exp_sum = 8'($urandom_range(0, 255));
      run_session(1'b1, $urandom_range(1, 12), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
